// File: rtl/memory_client_pkg.sv
// Shared definitions for the host-side UART memory protocol initiator.
// The command macros are the same byte values memory_controller decodes.

`ifndef MEMORY_PROTOCOL_DEFS
`define MEMORY_PROTOCOL_DEFS
`define COMMAND_WRITE 8'h57
`define COMMAND_READ  8'h52
`endif

package memory_client_pkg;

  localparam logic [7:0] CMD_BYTE_WRITE = `COMMAND_WRITE;
  localparam logic [7:0] CMD_BYTE_READ  = `COMMAND_READ;

  // One latched request as seen on the command port.
  typedef struct packed {
    logic        write;
    logic [7:0]  length;
    logic [15:0] addr;
  } req_t;

  // Which header byte is currently being sent.
  typedef enum logic [1:0] {
    HDR_CMD = 2'd0,
    HDR_LEN = 2'd1,
    HDR_AHI = 2'd2,
    HDR_ALO = 2'd3
  } hdr_field_e;

  // Header byte for a given request and header position.
  function automatic logic [7:0] header_byte(input req_t req, input hdr_field_e field);
    logic [7:0] b;
    b = '0;
    case (field)
      HDR_CMD: b = req.write ? CMD_BYTE_WRITE : CMD_BYTE_READ;
      HDR_LEN: b = req.length;
      HDR_AHI: b = req.addr[15:8];
      HDR_ALO: b = req.addr[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/memory_client.sv
// memory_client: turns one read/write request into the byte stream
// COMMAND, LENGTH, ADDR_HI, ADDR_LO, [data...] through a UART transmitter,
// and for reads collects LENGTH reply bytes from a UART receiver.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a request; cmd_ready high
// S_CMD   | sending the command byte
// S_LEN   | sending the length byte
// S_AHI   | sending address bits 15:8
// S_ALO   | sending address bits 7:0
// S_DATA  | streaming write data from wr_* to the transmitter
// R_DATA  | collecting read reply bytes, idle timer running
// FINISH  | one cycle before the done pulse, then back to IDLE

module memory_client
  import memory_client_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_length,
  input  logic [15:0] cmd_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        timeout,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        tx_busy,
  input  logic        received,
  input  logic [7:0]  rx_byte
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_S_CMD  = 3'd1;
  localparam logic [2:0] ST_S_LEN  = 3'd2;
  localparam logic [2:0] ST_S_AHI  = 3'd3;
  localparam logic [2:0] ST_S_ALO  = 3'd4;
  localparam logic [2:0] ST_S_DATA = 3'd5;
  localparam logic [2:0] ST_R_DATA = 3'd6;
  localparam logic [2:0] ST_FINISH = 3'd7;

  // Idle timer reload: reaching zero with no reply byte means TIMEOUT_CYCLES
  // full cycles have passed since the last byte (or since entering R_DATA).
  localparam logic [TIMEOUT_W-1:0] IDLE_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]           r_state;
  req_t                 r_req;
  logic [7:0]           r_remaining;
  logic [TIMEOUT_W-1:0] r_idle_cnt;
  logic                 r_tx_prev;
  logic                 r_rd_valid;
  logic [7:0]           r_rd_data;
  logic                 r_done;
  logic                 r_timeout;

  logic                 w_in_send;
  logic                 w_is_data;
  logic                 w_is_rdata;
  logic                 w_send_ok;
  logic                 w_wr_hs;
  logic                 w_transmit;
  logic                 w_accept;
  logic                 w_rx_take;
  logic                 w_idle_expired;
  logic [7:0]           w_tx_byte;
  hdr_field_e           w_field;

  // Decode which states send a byte and which header field they carry.
  always_comb begin
    w_in_send = 1'b0;
    w_field   = HDR_CMD;
    case (r_state)
      ST_S_CMD:  begin w_in_send = 1'b1; w_field = HDR_CMD; end
      ST_S_LEN:  begin w_in_send = 1'b1; w_field = HDR_LEN; end
      ST_S_AHI:  begin w_in_send = 1'b1; w_field = HDR_AHI; end
      ST_S_ALO:  begin w_in_send = 1'b1; w_field = HDR_ALO; end
      ST_S_DATA: w_in_send = 1'b1;
      default:   w_in_send = 1'b0;
    endcase
  end

  assign w_is_data  = (r_state == ST_S_DATA);
  assign w_is_rdata = (r_state == ST_R_DATA);

  // The previous-cycle guard hides the UART's one-cycle busy latency.
  assign w_send_ok  = w_in_send && !tx_busy && !r_tx_prev && !reset;
  assign w_wr_hs    = w_is_data && w_send_ok && wr_valid;
  assign w_transmit = w_is_data ? w_wr_hs : w_send_ok;
  assign w_tx_byte  = !w_transmit ? 8'h00 :
                      (w_is_data ? wr_data : header_byte(r_req, w_field));

  assign cmd_ready      = (r_state == ST_IDLE) && !reset;
  assign w_accept       = cmd_valid && cmd_ready;
  assign wr_ready       = w_is_data && w_send_ok;
  assign w_rx_take      = w_is_rdata && received;
  assign w_idle_expired = (r_idle_cnt == '0);

  assign transmit = w_transmit;
  assign tx_byte  = w_tx_byte;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign done     = r_done;
  assign timeout  = r_timeout;

  // Request sequencing: header bytes, then data out or replies in.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req       <= '{write: cmd_write, length: cmd_length, addr: cmd_addr};
            r_remaining <= cmd_length;
            r_state     <= ST_S_CMD;
          end
        end
        ST_S_CMD: if (w_transmit) r_state <= ST_S_LEN;
        ST_S_LEN: if (w_transmit) r_state <= ST_S_AHI;
        ST_S_AHI: if (w_transmit) r_state <= ST_S_ALO;
        ST_S_ALO: begin
          if (w_transmit) begin
            if (r_req.length == 8'd0) r_state <= ST_FINISH;
            else if (r_req.write)     r_state <= ST_S_DATA;
            else                      r_state <= ST_R_DATA;
          end
        end
        ST_S_DATA: begin
          if (w_wr_hs) begin
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) r_state <= ST_FINISH;
          end
        end
        ST_R_DATA: begin
          if (received) begin
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) r_state <= ST_FINISH;
          end else if (w_idle_expired) begin
            r_state <= ST_IDLE;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Read-reply idle timer: reload outside R_DATA and on every reply byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idle_cnt <= IDLE_LOAD;
    end else if (!w_is_rdata || received) begin
      r_idle_cnt <= IDLE_LOAD;
    end else if (!w_idle_expired) begin
      r_idle_cnt <= r_idle_cnt - 1'b1;
    end
  end

  // Registered pulses and reply data; stray rx bytes outside R_DATA are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_prev  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_prev  <= w_transmit;
      r_rd_valid <= w_rx_take;
      if (w_rx_take) r_rd_data <= rx_byte;
      r_done     <= (r_state == ST_FINISH);
      r_timeout  <= w_is_rdata && !received && w_idle_expired;
    end
  end

endmodule

// File: tb/tb_memory_client.sv
// Directed bench for memory_client with a queue-based model of the expected
// byte stream, reply bytes and completion pulses.

module tb_memory_client;

  localparam int T_CYC = 200;
  localparam int T_W   = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_length = 8'h00;
  logic [15:0] cmd_addr = 16'h0000;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        cmd_ready, wr_ready, rd_valid, done, timeout, transmit, tx_busy;
  logic [7:0]  rd_data, tx_byte;

  int checks = 0;
  int failures = 0;

  memory_client #(.TIMEOUT_CYCLES(T_CYC), .TIMEOUT_W(T_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_length(cmd_length), .cmd_addr(cmd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .timeout(timeout),
    .transmit(transmit), .tx_byte(tx_byte), .tx_busy(tx_busy),
    .received(received), .rx_byte(rx_byte)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // UART tx model: busy for 10 cycles starting the cycle after transmit.
  int busy_cnt = 0;
  always @(posedge clock) begin
    if (transmit) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Model state.
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_log[$];
  int exp_done = 0, exp_to = 0;
  int tx_cnt = 0, rd_cnt = 0, done_cnt = 0, to_cnt = 0, wr_ready_cnt = 0;
  int last_rd_cyc = 0, last_done_cyc = 0, last_to_cyc = 0;
  logic [7:0] last_rd_val = 8'h00;
  logic prev_tx = 1'b0;

  logic [7:0] lit_w  [7] = '{8'h57, 8'h03, 8'h0E, 8'hCD, 8'h42, 8'h43, 8'h44};
  logic [7:0] lit_r  [4] = '{8'h52, 8'h01, 8'h0A, 8'h10};
  logic [7:0] lit_w0 [4] = '{8'h57, 8'h00, 8'h12, 8'h34};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Compare process: every output event is checked against the model.
  always @(negedge clock) begin
    if (!reset) begin
      if (transmit) begin
        check("tx_guard_busy_prev", {30'd0, tx_busy, prev_tx}, 32'd0);
        if (exp_tx.size() == 0) check("tx_unexpected", {24'd0, tx_byte}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_tx.pop_front()});
        tx_log.push_back(tx_byte);
        tx_cnt++;
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) check("rd_unexpected", {24'd0, rd_data}, 32'hFFFF_FFFF);
        else check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
        rd_cnt++;
        last_rd_cyc = cyc;
        last_rd_val = rd_data;
      end
      if (done) begin
        check("done_expected", (exp_done > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_done > 0) exp_done--;
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (timeout) begin
        check("timeout_expected", (exp_to > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_to > 0) exp_to--;
        to_cnt++;
        last_to_cyc = cyc;
      end
      if (wr_ready) wr_ready_cnt++;
    end
    prev_tx = transmit;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] len, input logic [15:0] addr);
    int k = 0;
    bit acc = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_length = len; cmd_addr = addr;
    while (!acc && k < 100) begin
      @(negedge clock);
      acc = cmd_ready;
      tick();
      k++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", {31'd0, acc}, 32'd1);
    exp_tx.push_back(w ? 8'h57 : 8'h52);
    exp_tx.push_back(len);
    exp_tx.push_back(addr[15:8]);
    exp_tx.push_back(addr[7:0]);
  endtask

  task automatic feed_byte(input logic [7:0] d);
    int k = 0;
    bit hs = 1'b0;
    exp_tx.push_back(d);
    wr_valid = 1'b1; wr_data = d;
    while (!hs && k < 500) begin
      @(negedge clock);
      hs = wr_ready;
      tick();
      k++;
    end
    wr_valid = 1'b0;
    check("wr_handshake", {31'd0, hs}, 32'd1);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    received = 1'b1; rx_byte = b;
    tick();
    received = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string name);
    int k = 0;
    while (tx_cnt < n && k < 2000) begin tick(); k++; end
    if (tx_cnt < n) check(name, tx_cnt, n);
  endtask

  task automatic wait_done(input int n, input string name);
    int k = 0;
    while (done_cnt < n && k < 2000) begin tick(); k++; end
    if (done_cnt < n) check(name, done_cnt, n);
  endtask

  task automatic wait_to(input int n, input string name);
    int k = 0;
    while (to_cnt < n && k < T_CYC + 500) begin tick(); k++; end
    if (to_cnt < n) check(name, to_cnt, n);
  endtask

  initial begin
    int base, d0, r0, w0, t0;

    // Reset values.
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_outputs", {11'd0, transmit, wr_ready, rd_valid, done, timeout, tx_byte, rd_data}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_outputs", {11'd0, transmit, wr_ready, rd_valid, done, timeout, tx_byte, rd_data}, 32'd0);
    tick();

    // Write 0x0ECD, 3 bytes.
    base = tx_cnt; d0 = done_cnt; r0 = rd_cnt;
    exp_done++;
    send_cmd(1'b1, 8'd3, 16'h0ECD);
    feed_byte(8'h42); feed_byte(8'h43); feed_byte(8'h44);
    wait_done(d0 + 1, "wr3_done_wait");
    repeat (5) tick();
    check("wr3_tx_count", tx_cnt - base, 7);
    for (int i = 0; i < 7; i++) check("wr3_tx_log", {24'd0, tx_log[base + i]}, {24'd0, lit_w[i]});
    check("wr3_done_count", done_cnt - d0, 1);
    check("wr3_no_rd", rd_cnt - r0, 0);

    // Read 0x0A10, 1 byte.
    base = tx_cnt; d0 = done_cnt; r0 = rd_cnt;
    exp_done++;
    send_cmd(1'b0, 8'd1, 16'h0A10);
    wait_tx(base + 4, "rd1_hdr_wait");
    repeat (3) tick();
    exp_rd.push_back(8'h46);
    pulse_rx(8'h46);
    wait_done(d0 + 1, "rd1_done_wait");
    repeat (3) tick();
    check("rd1_tx_count", tx_cnt - base, 4);
    for (int i = 0; i < 4; i++) check("rd1_tx_log", {24'd0, tx_log[base + i]}, {24'd0, lit_r[i]});
    check("rd1_rd_count", rd_cnt - r0, 1);
    check("rd1_rd_value", {24'd0, last_rd_val}, 32'h46);
    check("rd1_done_latency", last_done_cyc - last_rd_cyc, 1);

    // Write length 0.
    base = tx_cnt; d0 = done_cnt; w0 = wr_ready_cnt;
    exp_done++;
    send_cmd(1'b1, 8'd0, 16'h1234);
    wait_done(d0 + 1, "wr0_done_wait");
    repeat (3) tick();
    check("wr0_tx_count", tx_cnt - base, 4);
    for (int i = 0; i < 4; i++) check("wr0_tx_log", {24'd0, tx_log[base + i]}, {24'd0, lit_w0[i]});
    check("wr0_no_wr_ready", wr_ready_cnt - w0, 0);

    // Write length 2 with a 50-cycle wr_valid stall.
    base = tx_cnt; d0 = done_cnt; t0 = to_cnt;
    exp_done++;
    send_cmd(1'b1, 8'd2, 16'h0100);
    wait_tx(base + 4, "stall_hdr_wait");
    repeat (50) tick();
    check("stall_no_tx", tx_cnt - base, 4);
    feed_byte(8'hAA); feed_byte(8'h55);
    wait_done(d0 + 1, "stall_done_wait");
    check("stall_tx_count", tx_cnt - base, 6);
    check("stall_no_timeout", to_cnt - t0, 0);

    // Read length 2, one reply, then silence.
    base = tx_cnt; d0 = done_cnt; r0 = rd_cnt; t0 = to_cnt;
    exp_to++;
    send_cmd(1'b0, 8'd2, 16'h2000);
    wait_tx(base + 4, "to_hdr_wait");
    repeat (2) tick();
    exp_rd.push_back(8'h99);
    pulse_rx(8'h99);
    wait_to(t0 + 1, "to_pulse_wait");
    @(negedge clock);
    check("to_cmd_ready_next", {31'd0, cmd_ready}, 32'd1);
    check("to_latency", last_to_cyc - last_rd_cyc, T_CYC);
    check("to_rd_count", rd_cnt - r0, 1);
    check("to_no_done", done_cnt - d0, 0);
    check("to_count", to_cnt - t0, 1);
    tick();

    // Reset in S_AHI with a stray rx byte during S_LEN.
    base = tx_cnt; d0 = done_cnt; r0 = rd_cnt; t0 = to_cnt;
    send_cmd(1'b0, 8'd1, 16'h3344);
    wait_tx(base + 1, "rst_cmd_wait");
    pulse_rx(8'hEE);
    wait_tx(base + 2, "rst_len_wait");
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("midrst_outputs", {10'd0, cmd_ready, transmit, wr_ready, rd_valid, done, timeout, tx_byte, rd_data}, 32'd0);
    tick();
    reset = 1'b0;
    exp_tx.delete();
    repeat (20) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_rd", rd_cnt - r0, 0);
    check("midrst_no_timeout", to_cnt - t0, 0);
    check("midrst_tx_count", tx_cnt - base, 2);

    // Recovery read after the abandoned request.
    base = tx_cnt; d0 = done_cnt;
    exp_done++;
    send_cmd(1'b0, 8'd1, 16'h3344);
    wait_tx(base + 4, "rec_hdr_wait");
    tick();
    exp_rd.push_back(8'h5A);
    pulse_rx(8'h5A);
    wait_done(d0 + 1, "rec_done_wait");
    check("rec_rd_value", {24'd0, last_rd_val}, 32'h5A);
    check("model_tx_drained", exp_tx.size(), 0);
    check("model_rd_drained", exp_rd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
